// File: rtl/id_ex_stage_reg_if.sv
// Signal bundle between decode, write-back and the ID/EX pipeline register.
// The master modport drives the decode/write-back side; the slave modport is the stage itself.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rt_used;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_wb_en;
    logic              id_mem_read;

    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              stall;
    logic              flush;
    logic              load_use_stall;

    logic              ex_valid;
    logic              ex_wb_en;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output id_valid, id_rs, id_rt, id_rt_used, id_rd, id_rs_data, id_rt_data,
               id_imm, id_ctrl, id_wb_en, id_mem_read,
               wb_en, wb_addr, wb_data, stall, flush,
        input  load_use_stall, ex_valid, ex_wb_en, ex_mem_read, ex_rs, ex_rt, ex_rd,
               ex_a, ex_b, ex_imm, ex_ctrl
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rt_used, id_rd, id_rs_data, id_rt_data,
               id_imm, id_ctrl, id_wb_en, id_mem_read,
               wb_en, wb_addr, wb_data, stall, flush,
        output load_use_stall, ex_valid, ex_wb_en, ex_mem_read, ex_rs, ex_rt, ex_rd,
               ex_a, ex_b, ex_imm, ex_ctrl
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register: write-back bypass on capture, operand patching while
// stalled, load-use hazard detection, bubble insertion and flush.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
) (
    input  logic               clock,
    input  logic               rst,
    id_ex_stage_reg_if.slave   io_bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } state_t;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_wb_en;
    logic              r_mem_read;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_imm;
    logic [CTRL_W-1:0] r_ctrl;

    logic              w_load_use;
    logic              w_capture;
    logic              w_patch_a;
    logic              w_patch_b;
    logic              w_wb_live;
    logic              w_rs_byp;
    logic              w_rt_byp;
    logic [DATA_W-1:0] w_a_in;
    logic [DATA_W-1:0] w_b_in;

    // A write to register 0 is architecturally void, so it never forwards.
    assign w_wb_live = io_bus.wb_en && (io_bus.wb_addr != ZERO_REG);

    // The register file samples wb_data on the same edge we do, so its read data is stale.
    assign w_rs_byp = w_wb_live && (io_bus.wb_addr == io_bus.id_rs);
    assign w_rt_byp = w_wb_live && (io_bus.wb_addr == io_bus.id_rt);

    always_comb begin
        w_a_in = io_bus.id_rs_data;
        w_b_in = io_bus.id_rt_data;
        if (io_bus.id_rs == ZERO_REG) begin
            w_a_in = '0;
        end else if (w_rs_byp) begin
            w_a_in = io_bus.wb_data;
        end
        if (io_bus.id_rt == ZERO_REG) begin
            w_b_in = '0;
        end else if (w_rt_byp) begin
            w_b_in = io_bus.wb_data;
        end
    end

    assign w_load_use = io_bus.id_valid && (r_state == ST_VALID) && r_mem_read &&
                        (r_rd != ZERO_REG) &&
                        ((r_rd == io_bus.id_rs) ||
                         (io_bus.id_rt_used && (r_rd == io_bus.id_rt)));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_patch_a    = 1'b0;
        w_patch_b    = 1'b0;
        if (io_bus.flush) begin
            w_state_next = ST_EMPTY;
        end else if (io_bus.stall) begin
            w_patch_a = (r_state == ST_VALID) && w_wb_live && (io_bus.wb_addr == r_rs);
            w_patch_b = (r_state == ST_VALID) && w_wb_live && (io_bus.wb_addr == r_rt);
        end else if (w_load_use || !io_bus.id_valid) begin
            w_state_next = ST_EMPTY;
        end else begin
            w_state_next = ST_VALID;
            w_capture    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The whole payload is reset, not just the valid bit, because every ex_* output must read 0.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wb_en    <= 1'b0;
            r_mem_read <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_imm      <= '0;
            r_ctrl     <= '0;
        end else if (w_capture) begin
            r_wb_en    <= io_bus.id_wb_en;
            r_mem_read <= io_bus.id_mem_read;
            r_rs       <= io_bus.id_rs;
            r_rt       <= io_bus.id_rt;
            r_rd       <= io_bus.id_rd;
            r_a        <= w_a_in;
            r_b        <= w_b_in;
            r_imm      <= io_bus.id_imm;
            r_ctrl     <= io_bus.id_ctrl;
        end else begin
            if (w_state_next == ST_EMPTY) begin
                r_wb_en    <= 1'b0;
                r_mem_read <= 1'b0;
            end
            if (w_patch_a) begin
                r_a <= io_bus.wb_data;
            end
            if (w_patch_b) begin
                r_b <= io_bus.wb_data;
            end
        end
    end

    assign io_bus.load_use_stall = w_load_use;
    assign io_bus.ex_valid       = (r_state == ST_VALID);
    assign io_bus.ex_wb_en       = r_wb_en;
    assign io_bus.ex_mem_read    = r_mem_read;
    assign io_bus.ex_rs          = r_rs;
    assign io_bus.ex_rt          = r_rt;
    assign io_bus.ex_rd          = r_rd;
    assign io_bus.ex_a           = r_a;
    assign io_bus.ex_b           = r_b;
    assign io_bus.ex_imm         = r_imm;
    assign io_bus.ex_ctrl        = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: a directed vector table plus hand-written
// sequences for stall patching, stall+flush, back-to-back flow and asynchronous reset.
module tb_id_ex_stage_reg;

    logic clock;
    logic rst;
    int   n_checks;
    int   n_errors;

    id_ex_stage_reg_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(16)) bus_if ();

    id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CTRL_W(16)) dut (
        .clock (clock),
        .rst   (rst),
        .io_bus(bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rt_used;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic        id_wb_en;
        logic        mem_read;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        flush;
        logic        exp_lus;
        logic        exp_valid;
        logic        exp_wb_en;
        logic        exp_mem_read;
        logic [4:0]  exp_rd;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_id(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                            input logic rt_used, input logic [4:0] rd,
                            input logic [31:0] rs_data, input logic [31:0] rt_data,
                            input logic [31:0] imm, input logic [15:0] ctrl,
                            input logic id_wb_en, input logic mem_read);
        bus_if.id_valid    = valid;
        bus_if.id_rs       = rs;
        bus_if.id_rt       = rt;
        bus_if.id_rt_used  = rt_used;
        bus_if.id_rd       = rd;
        bus_if.id_rs_data  = rs_data;
        bus_if.id_rt_data  = rt_data;
        bus_if.id_imm      = imm;
        bus_if.id_ctrl     = ctrl;
        bus_if.id_wb_en    = id_wb_en;
        bus_if.id_mem_read = mem_read;
    endtask

    task automatic drive_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        bus_if.wb_en   = en;
        bus_if.wb_addr = addr;
        bus_if.wb_data = data;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ex_valid"},    32'(bus_if.ex_valid),    32'h0);
        check({tag, ".ex_wb_en"},    32'(bus_if.ex_wb_en),    32'h0);
        check({tag, ".ex_mem_read"}, 32'(bus_if.ex_mem_read), 32'h0);
        check({tag, ".ex_rs"},       32'(bus_if.ex_rs),       32'h0);
        check({tag, ".ex_rt"},       32'(bus_if.ex_rt),       32'h0);
        check({tag, ".ex_rd"},       32'(bus_if.ex_rd),       32'h0);
        check({tag, ".ex_a"},        bus_if.ex_a,             32'h0);
        check({tag, ".ex_b"},        bus_if.ex_b,             32'h0);
        check({tag, ".ex_imm"},      bus_if.ex_imm,           32'h0);
        check({tag, ".ex_ctrl"},     32'(bus_if.ex_ctrl),     32'h0);
    endtask

    task automatic apply_vec(input int idx);
        vec_t  v;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("vec%0d", idx);
        @(negedge clock);
        drive_id(v.valid, v.rs, v.rt, v.rt_used, v.rd, v.rs_data, v.rt_data,
                 32'h100 + 32'(idx), 16'h0A00 + 16'(idx), v.id_wb_en, v.mem_read);
        drive_wb(v.wb_en, v.wb_addr, v.wb_data);
        bus_if.stall = 1'b0;
        bus_if.flush = v.flush;
        #1;
        check({tag, ".load_use_stall"}, 32'(bus_if.load_use_stall), 32'(v.exp_lus));
        @(posedge clock);
        #1;
        check({tag, ".ex_valid"},    32'(bus_if.ex_valid),    32'(v.exp_valid));
        check({tag, ".ex_wb_en"},    32'(bus_if.ex_wb_en),    32'(v.exp_wb_en));
        check({tag, ".ex_mem_read"}, 32'(bus_if.ex_mem_read), 32'(v.exp_mem_read));
        check({tag, ".ex_rd"},       32'(bus_if.ex_rd),       32'(v.exp_rd));
        check({tag, ".ex_a"},        bus_if.ex_a,             v.exp_a);
        check({tag, ".ex_b"},        bus_if.ex_b,             v.exp_b);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Fields: valid rs rt rt_used rd rs_data rt_data id_wb_en mem_read wb_en wb_addr wb_data flush
        //         | lus valid wb_en mem_read rd a b (expected after the edge)
        vecs[0]  = '{1'b1, 5'd1,  5'd2,  1'b1, 5'd3,  32'h11,   32'h22,  1'b1, 1'b0, 1'b0, 5'd0,  32'h0,    1'b0,
                     1'b0, 1'b1, 1'b1, 1'b0, 5'd3,  32'h11,   32'h22};
        vecs[1]  = '{1'b1, 5'd5,  5'd6,  1'b1, 5'd7,  32'hAAAA, 32'h66,  1'b1, 1'b0, 1'b1, 5'd5,  32'h5555, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b0, 5'd7,  32'h5555, 32'h66};
        vecs[2]  = '{1'b1, 5'd0,  5'd5,  1'b1, 5'd4,  32'hAAAA, 32'h77,  1'b1, 1'b0, 1'b1, 5'd0,  32'h5555, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b0, 5'd4,  32'h0,    32'h77};
        vecs[3]  = '{1'b1, 5'd9,  5'd10, 1'b1, 5'd8,  32'h99,   32'h100, 1'b1, 1'b1, 1'b1, 5'd10, 32'hCAFE, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 5'd8,  32'h99,   32'hCAFE};
        vecs[4]  = '{1'b1, 5'd1,  5'd8,  1'b1, 5'd2,  32'h31,   32'h32,  1'b1, 1'b0, 1'b0, 5'd0,  32'h0,    1'b0,
                     1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  32'h99,   32'hCAFE};
        vecs[5]  = '{1'b1, 5'd3,  5'd4,  1'b1, 5'd8,  32'h33,   32'h44,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,    1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 5'd8,  32'h33,   32'h44};
        vecs[6]  = '{1'b1, 5'd1,  5'd8,  1'b0, 5'd2,  32'h31,   32'h88,  1'b1, 1'b0, 1'b0, 5'd0,  32'h0,    1'b0,
                     1'b0, 1'b1, 1'b1, 1'b0, 5'd2,  32'h31,   32'h88};
        vecs[7]  = '{1'b1, 5'd2,  5'd0,  1'b0, 5'd9,  32'h21,   32'hFF,  1'b1, 1'b1, 1'b0, 5'd0,  32'h0,    1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  32'h21,   32'h0};
        vecs[8]  = '{1'b1, 5'd9,  5'd1,  1'b0, 5'd5,  32'h91,   32'h92,  1'b1, 1'b0, 1'b0, 5'd0,  32'h0,    1'b0,
                     1'b1, 1'b0, 1'b0, 1'b0, 5'd9,  32'h21,   32'h0};
        vecs[9]  = '{1'b0, 5'd12, 5'd13, 1'b1, 5'd14, 32'hC,    32'hD,   1'b1, 1'b0, 1'b0, 5'd0,  32'h0,    1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  32'h21,   32'h0};
        vecs[10] = '{1'b1, 5'd12, 5'd13, 1'b1, 5'd14, 32'hC,    32'hD,   1'b1, 1'b0, 1'b0, 5'd0,  32'h0,    1'b0,
                     1'b0, 1'b1, 1'b1, 1'b0, 5'd14, 32'hC,    32'hD};
        vecs[11] = '{1'b0, 5'd1,  5'd2,  1'b1, 5'd3,  32'h1,    32'h2,   1'b1, 1'b1, 1'b0, 5'd0,  32'h0,    1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 5'd14, 32'hC,    32'hD};
        vecs[12] = '{1'b1, 5'd1,  5'd2,  1'b1, 5'd3,  32'h1,    32'h2,   1'b1, 1'b1, 1'b0, 5'd0,  32'h0,    1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  32'h1,    32'h2};
        vecs[13] = '{1'b1, 5'd4,  5'd5,  1'b0, 5'd6,  32'h4,    32'h5,   1'b1, 1'b0, 1'b0, 5'd0,  32'h0,    1'b1,
                     1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  32'h1,    32'h2};

        rst = 1'b1;
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0);
        drive_wb(1'b0, 5'd0, 32'h0);
        bus_if.stall = 1'b0;
        bus_if.flush = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply_vec(i);
        end

        // Stall with write-back patching of the held operands.
        @(negedge clock);
        drive_id(1'b1, 5'd20, 5'd9, 1'b1, 5'd21, 32'h20, 32'h0909, 32'h77, 16'h005A, 1'b1, 1'b0);
        drive_wb(1'b0, 5'd0, 32'h0);
        bus_if.flush = 1'b0;
        @(posedge clock);
        #1;
        check("stall_setup.ex_b", bus_if.ex_b, 32'h0909);
        @(negedge clock);
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 32'hDEAD, 32'hD00D, 32'h1, 16'h1, 1'b0, 1'b1);
        drive_wb(1'b1, 5'd9, 32'hBEEF);
        bus_if.stall = 1'b1;
        @(posedge clock);
        #1;
        check("stall_patch.ex_b",     bus_if.ex_b,              32'hBEEF);
        check("stall_patch.ex_a",     bus_if.ex_a,              32'h20);
        check("stall_patch.ex_rs",    32'(bus_if.ex_rs),        32'd20);
        check("stall_patch.ex_rt",    32'(bus_if.ex_rt),        32'd9);
        check("stall_patch.ex_rd",    32'(bus_if.ex_rd),        32'd21);
        check("stall_patch.ex_imm",   bus_if.ex_imm,            32'h77);
        check("stall_patch.ex_ctrl",  32'(bus_if.ex_ctrl),      32'h005A);
        check("stall_patch.ex_valid", 32'(bus_if.ex_valid),     32'h1);
        check("stall_patch.ex_wb_en", 32'(bus_if.ex_wb_en),     32'h1);
        check("stall_patch.ex_mr",    32'(bus_if.ex_mem_read),  32'h0);
        @(negedge clock);
        drive_wb(1'b1, 5'd20, 32'h1111);
        @(posedge clock);
        #1;
        check("stall_patch_a.ex_a", bus_if.ex_a, 32'h1111);
        check("stall_patch_a.ex_b", bus_if.ex_b, 32'hBEEF);

        // Stall and flush on the same edge: flush wins.
        @(negedge clock);
        bus_if.stall = 1'b0;
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd10, 32'h1, 32'h2, 32'h3, 16'h4, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        check("flush_setup.ex_mem_read", 32'(bus_if.ex_mem_read), 32'h1);
        @(negedge clock);
        drive_id(1'b1, 5'd4, 5'd5, 1'b0, 5'd6, 32'h4, 32'h5, 32'h6, 16'h7, 1'b1, 1'b0);
        bus_if.stall = 1'b1;
        bus_if.flush = 1'b1;
        @(posedge clock);
        #1;
        check("stall_flush.ex_valid",    32'(bus_if.ex_valid),    32'h0);
        check("stall_flush.ex_wb_en",    32'(bus_if.ex_wb_en),    32'h0);
        check("stall_flush.ex_mem_read", 32'(bus_if.ex_mem_read), 32'h0);
        check("stall_flush.ex_rd",       32'(bus_if.ex_rd),       32'd10);

        // Back-to-back valid instructions with no hazards.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus_if.stall = 1'b0;
            bus_if.flush = 1'b0;
            drive_id(1'b1, 5'(i + 1), 5'(i + 11), 1'b1, 5'(i + 21), 32'h1000 + 32'(i),
                     32'h2000 + 32'(i), 32'h3000 + 32'(i), 16'h0040 + 16'(i), 1'b1, 1'b0);
            @(posedge clock);
            #1;
            check($sformatf("b2b%0d.ex_valid", i), 32'(bus_if.ex_valid), 32'h1);
            check($sformatf("b2b%0d.ex_rs", i),    32'(bus_if.ex_rs),    32'(i + 1));
            check($sformatf("b2b%0d.ex_rt", i),    32'(bus_if.ex_rt),    32'(i + 11));
            check($sformatf("b2b%0d.ex_rd", i),    32'(bus_if.ex_rd),    32'(i + 21));
            check($sformatf("b2b%0d.ex_a", i),     bus_if.ex_a,          32'h1000 + 32'(i));
            check($sformatf("b2b%0d.ex_b", i),     bus_if.ex_b,          32'h2000 + 32'(i));
            check($sformatf("b2b%0d.ex_imm", i),   bus_if.ex_imm,        32'h3000 + 32'(i));
            check($sformatf("b2b%0d.ex_ctrl", i),  32'(bus_if.ex_ctrl),  32'h0040 + 32'(i));
        end

        // Asynchronous reset in the middle of a cycle, no clock edge in between.
        @(negedge clock);
        drive_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 32'h1234, 32'h5678, 32'h9, 16'h9, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        check("pre_reset.ex_valid", 32'(bus_if.ex_valid), 32'h1);
        check("pre_reset.ex_a",     bus_if.ex_a,          32'h1234);
        @(negedge clock);
        bus_if.id_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clock);
        rst = 1'b0;
        @(posedge clock);
        #1;
        check("post_reset.ex_valid", 32'(bus_if.ex_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
